data_bus_responder: RTL and testbench

//  Responder end of the core's data bus (busAddr/busWData/busRData). Holds a word-organised data RAM,

---
 rtl/data_bus_responder_if.sv | 22 ++
 rtl/data_bus_responder.sv | 161 ++++++++++++++++
 tb/tb_data_bus_responder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
// Data-bus handshake between the core (master) and the data RAM responder (slave).
// Carries request, store data, load result and the one-cycle ready/error completion.
interface data_bus_responder_if;
  logic        busReq;
  logic        busWe;
  logic [2:0]  busFunct3;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        busReady;
  logic        busErr;

  modport master (
    output busReq, busWe, busFunct3, busAddr, busWData,
    input  busRData, busReady, busErr
  );

  modport slave (
    input  busReq, busWe, busFunct3, busAddr, busWData,
    output busRData, busReady, busErr
  );
endinterface

// File: rtl/data_bus_responder.sv
// Data-bus responder: word RAM with RV32I byte/half/word loads and stores, programmable wait,
// one-cycle busReady completion. Define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module data_bus_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [31:0]           acc_addr, acc_wdata, offset, word, lane_data, load_val, wr_data;
  logic                  acc_we, in_range, bad_f3, acc_err, enter_resp, commit;
  logic [2:0]            acc_f3;
  logic [1:0]            lane;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] idx;

  // In IDLE the access is evaluated straight from the bus so a zero-wait access can
  // complete on the accept edge; afterwards the latched copy is used.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    acc_f3    = f3_q;
    if (state_q == S_IDLE) begin
      acc_addr  = bus.busAddr;
      acc_wdata = bus.busWData;
      acc_we    = bus.busWe;
      acc_f3    = bus.busFunct3;
    end

    offset   = acc_addr - BASE_ADDR;
    in_range = (acc_addr >= BASE_ADDR) && (offset[31:ADDR_WIDTH+2] == '0);
    bad_f3   = (acc_f3 inside {3'b011, 3'b110, 3'b111}) || (acc_we && acc_f3[2]);
    idx      = offset[ADDR_WIDTH+1:2];

    lane = acc_addr[1:0];
    case (acc_f3[1:0])
      2'b01:   lane[0] = 1'b0;
      2'b10:   lane    = 2'b00;
      default: ;
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    acc_err = !in_range || bad_f3 || (lane != acc_addr[1:0]);
`else
    acc_err = !in_range || bad_f3;
`endif

    word      = mem_q[idx];
    lane_data = word >> {lane, 3'b000};
    case (acc_f3)
      3'b000:  load_val = {{24{lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_val = {{16{lane_data[15]}}, lane_data[15:0]};
      3'b010:  load_val = lane_data;
      3'b100:  load_val = {24'b0, lane_data[7:0]};
      3'b101:  load_val = {16'b0, lane_data[15:0]};
      default: load_val = '0;
    endcase

    case (acc_f3[1:0])
      2'b00: begin
        wr_data = {4{acc_wdata[7:0]}};
        be      = 4'b0001 << lane;
      end
      2'b01: begin
        wr_data = {2{acc_wdata[15:0]}};
        be      = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = acc_wdata;
        be      = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.busReq) begin
        cnt_d   = '0;
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) state_d = S_RESP;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    commit     = enter_resp && acc_we && !acc_err && reset;

    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (acc_we || acc_err) ? 32'h0 : load_val;
      err_d   = acc_err;
    end else if (state_q == S_RESP) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.busReq) begin
      addr_q  <= bus.busAddr;
      wdata_q <= bus.busWData;
      we_q    <= bus.busWe;
      f3_q    <= bus.busFunct3;
    end
  end

  // NOTE: RAM contents are deliberately not reset; only the commit strobe is gated by reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.busReady = (state_q == S_RESP);
  assign bus.busErr   = err_q;
  assign bus.busRData = rdata_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed spec cases plus random accesses
// checked against a byte-addressed reference model; a second zero-wait instance covers back-to-back.
module tb_data_bus_responder;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_bus_responder_if bus1 ();
  data_bus_responder_if bus0 ();

  data_bus_responder #(.ADDR_WIDTH(8), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  data_bus_responder #(.ADDR_WIDTH(8), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] ram_model [1024];

  // Reference model: byte-addressed memory, access rules applied with plain arithmetic.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp_rd,
                              output logic exp_err);
    int size;
    longint off;
    logic [31:0] val;
    exp_rd  = '0;
    exp_err = 1'b0;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (f3 inside {3'd3, 3'd6, 3'd7}) exp_err = 1'b1;
    if (we && (f3 inside {3'd4, 3'd5})) exp_err = 1'b1;
    off = longint'(addr) - longint'(BASE);
    if (off < 0 || off >= 1024) exp_err = 1'b1;
    if ((addr % 32'(size)) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      exp_err = 1'b1;
`else
      off = off - longint'(addr % 32'(size));
`endif
    end
    if (exp_err) return;
    if (we) begin
      for (int b = 0; b < size; b++) ram_model[int'(off) + b] = 8'(wdata >> (8 * b));
    end else begin
      val = '0;
      for (int b = 0; b < size; b++) val = val | (32'(ram_model[int'(off) + b]) << (8 * b));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
      exp_rd = val;
    end
  endtask

  // One access on the WAIT_STATES=1 instance; returns in IDLE, #1 after the edge following RESP.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                           output int lat);
    @(negedge clk);
    bus1.busReq = 1'b1; bus1.busWe = we; bus1.busFunct3 = f3;
    bus1.busAddr = addr; bus1.busWData = wdata;
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      bus1.busReq = 1'b0;
      if (bus1.busReady) begin
        rd = bus1.busRData;
        er = bus1.busErr;
        break;
      end
    end
    checks++;
    if (bus1.busReady !== 1'b1) begin
      errors++;
      $display("FAIL access_timeout addr=%h: busReady not seen within 20 cycles", addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic acc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                     output logic [31:0] exp_rd, output logic exp_err, output int lat);
    do_access(we, f3, addr, wdata, rd, er, lat);
    model_access(we, f3, addr, wdata, exp_rd, exp_err);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus1.busReady, bus1.busErr, bus1.busRData} !== 34'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h, want all 0",
               bus1.busReady, bus1.busErr, bus1.busRData);
    end
    checks++;
    if ({bus0.busReady, bus0.busErr, bus0.busRData} !== 34'b0) begin
      errors++;
      $display("FAIL reset_outputs_w0: got rdy=%b err=%b rd=%h, want all 0",
               bus0.busReady, bus0.busErr, bus0.busRData);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    for (int w = 0; w < 256; w++) begin
      acc(1'b1, 3'b010, BASE + 32'(4 * w), $urandom, rd, er, erd, eer, lat);
      checks++;
      if (er !== 1'b0 || rd !== 32'h0) begin
        errors++;
        $display("FAIL fill_store word=%0d: err=%b rd=%h, want err=0 rd=0", w, er, rd);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd, erd, word0;
    logic er, eer;
    int lat;
    // Case 1: word store / load, latency and pulse width
    acc(1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", er); end
    acc(1'b0, 3'b010, 32'h1000_0004, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", er); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    checks++;
    if (bus1.busReady !== 1'b0 || bus1.busRData !== 32'h0) begin
      errors++;
      $display("FAIL ready_pulse: after RESP rdy=%b rd=%h, want 0/0", bus1.busReady, bus1.busRData);
    end
    // Case 2: byte store into a cleared word
    acc(1'b1, 3'b010, 32'h1000_0008, 32'h0, rd, er, erd, eer, lat);
    acc(1'b1, 3'b000, 32'h1000_0009, 32'h0000_0080, rd, er, erd, eer, lat);
    acc(1'b0, 3'b000, 32'h1000_0009, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", rd); end
    acc(1'b0, 3'b100, 32'h1000_0009, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zext: got %h want 00000080", rd); end
    acc(1'b0, 3'b010, 32'h1000_0008, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h0000_8000) begin errors++; $display("FAIL sb_lane: got %h want 00008000", rd); end
    // Case 3: half store into upper lanes of a cleared word
    acc(1'b1, 3'b010, 32'h1000_0010, 32'h0, rd, er, erd, eer, lat);
    acc(1'b1, 3'b001, 32'h1000_0012, 32'h0000_8001, rd, er, erd, eer, lat);
    acc(1'b0, 3'b001, 32'h1000_0012, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_sext: got %h want ffff8001", rd); end
    acc(1'b0, 3'b101, 32'h1000_0012, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu_zext: got %h want 00008001", rd); end
    acc(1'b0, 3'b010, 32'h1000_0010, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== 32'h8001_0000) begin errors++; $display("FAIL sh_lane: got %h want 80010000", rd); end
    // Case 4: out-of-range, illegal encodings, misalignment
    acc(1'b0, 3'b010, 32'h1000_0000, 32'h0, word0, er, erd, eer, lat);
    acc(1'b0, 3'b010, 32'h0FFF_FFFC, 32'h0, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL below_range: err=%b rd=%h want 1/0", er, rd); end
    acc(1'b1, 3'b010, 32'h1000_0400, 32'h5555_AAAA, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL above_range: err=%b want 1", er); end
    acc(1'b0, 3'b010, 32'h1000_0000, 32'h0, rd, er, erd, eer, lat);
    checks++; if (rd !== word0) begin errors++; $display("FAIL ram_unchanged: got %h want %h", rd, word0); end
    acc(1'b1, 3'b100, 32'h1000_0000, 32'h0000_00FF, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL store_bu: err=%b want 1", er); end
    acc(1'b0, 3'b011, 32'h1000_0000, 32'h0, rd, er, erd, eer, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL funct3_011: err=%b rd=%h want 1/0", er, rd); end
    acc(1'b0, 3'b010, 32'h1000_0002, 32'h0, rd, er, erd, eer, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_trap: err=%b rd=%h want 1/0", er, rd); end
`else
    checks++; if (er !== 1'b0 || rd !== word0) begin errors++; $display("FAIL misalign_align: err=%b rd=%h want 0/%h", er, rd, word0); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr;
    logic er, eer, we;
    logic [2:0] f3;
    int lat, r;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) addr = BASE + 32'h400 + 32'($urandom_range(0, 15));
      else             addr = BASE + 32'($urandom_range(0, 1023));
      acc(we, f3, addr, $urandom, rd, er, erd, eer, lat);
      checks++;
      if (rd !== erd || er !== eer || lat !== 2) begin
        errors++;
        $display("FAIL random_%0d we=%b f3=%0d addr=%h: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=2",
                 n, we, f3, addr, rd, er, lat, erd, eer);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    acc(1'b1, 3'b010, BASE + 32'h20, 32'h1111_1111, rd, er, erd, eer, lat);
    @(negedge clk);
    bus1.busReq = 1'b1; bus1.busWe = 1'b1; bus1.busFunct3 = 3'b010;
    bus1.busAddr = BASE + 32'h20; bus1.busWData = 32'h2222_2222;
    @(posedge clk); #1;
    bus1.busReq = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus1.busReady, bus1.busErr, bus1.busRData} !== 34'b0) begin
      errors++;
      $display("FAIL abort_outputs: rdy=%b err=%b rd=%h, want all 0", bus1.busReady, bus1.busErr, bus1.busRData);
    end
    @(negedge clk) reset = 1'b1;
    acc(1'b0, 3'b010, BASE + 32'h20, 32'h0, rd, er, erd, eer, lat);
    checks++;
    if (rd !== 32'h1111_1111 || lat !== 2) begin
      errors++;
      $display("FAIL abort_dropped: got rd=%h lat=%0d, want 11111111 lat=2", rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4];
    logic [31:0] exp;
    int k;
    bit exp_rdy;
    for (int j = 0; j < 4; j++) data[j] = $urandom;
    for (int i = 0; i < 16; i++) begin
      k = i / 2;
      @(negedge clk);
      bus0.busReq = 1'b1; bus0.busWe = (k % 2 == 0); bus0.busFunct3 = 3'b010;
      bus0.busAddr = BASE + 32'(28 * (k / 2)); bus0.busWData = data[k/2];
      @(posedge clk); #1;
      exp_rdy = (i % 2 == 0);
      checks++;
      if (bus0.busReady !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready cycle=%0d: got %b want %b", i, bus0.busReady, exp_rdy);
      end
      if (exp_rdy) begin
        exp = (k % 2 == 0) ? 32'h0 : data[k/2];
        checks++;
        if (bus0.busRData !== exp || bus0.busErr !== 1'b0) begin
          errors++;
          $display("FAIL b2b_data cmd=%0d: got rd=%h err=%b, want rd=%h err=0", k, bus0.busRData, bus0.busErr, exp);
        end
      end
    end
    bus0.busReq = 1'b0;
  endtask

  initial begin
    bus1.busReq = 1'b0; bus1.busWe = 1'b0; bus1.busFunct3 = '0; bus1.busAddr = '0; bus1.busWData = '0;
    bus0.busReq = 1'b0; bus0.busWe = 1'b0; bus0.busFunct3 = '0; bus0.busAddr = '0; bus0.busWData = '0;
    test_reset();
    test_fill();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
